// File: rtl/jtag_tap_sampled_if.sv
// JTAG pins plus the USER data-register capture/update strobes, shared by the
// clk-sampled TAP (slave) and whatever drives the pins (master).
interface jtag_tap_sampled_if #(
    parameter int IR_LEN = 5,
    parameter int DR_LEN = 32
);
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              tdo;
    logic [3:0]        tap_state;
    logic [IR_LEN-1:0] ir_value;
    logic [DR_LEN-1:0] dr_capture_data;
    logic              dr_capture_strobe;
    logic [DR_LEN-1:0] dr_update_data;
    logic              dr_update_valid;

    modport master (
        output tck, tms, tdi, dr_capture_data,
        input  tdo, tap_state, ir_value, dr_capture_strobe, dr_update_data, dr_update_valid
    );

    modport slave (
        input  tck, tms, tdi, dr_capture_data,
        output tdo, tap_state, ir_value, dr_capture_strobe, dr_update_data, dr_update_valid
    );
endinterface

// File: rtl/jtag_tap_sampled.sv
// 1149.1 TAP controller with IR, BYPASS, IDCODE and one USER DR; tck/tms/tdi are
// oversampled on clk and all actions fire on the synchronized tck edges.
//  state | meaning
//  TLR F, RTI C                 | reset / idle
//  SelDR 7 CapDR 6 ShDR 2 Ex1DR 1 PauDR 3 Ex2DR 0 UpdDR 5 | data-register column
//  SelIR 4 CapIR E ShIR A Ex1IR 9 PauIR B Ex2IR 8 UpdIR D | instruction-register column
module jtag_tap_sampled #(
    parameter int                IR_LEN      = 5,
    parameter logic [31:0]       IDCODE_VAL  = 32'h10001001,
    parameter logic [IR_LEN-1:0] USER_IR     = 5'h11,
    parameter int                DR_LEN      = 32,
    parameter int                SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    jtag_tap_sampled_if.slave bus
);
    localparam logic [3:0] TLR    = 4'hF;
    localparam logic [3:0] RTI    = 4'hC;
    localparam logic [3:0] SEL_DR = 4'h7;
    localparam logic [3:0] CAP_DR = 4'h6;
    localparam logic [3:0] SH_DR  = 4'h2;
    localparam logic [3:0] EX1_DR = 4'h1;
    localparam logic [3:0] PAU_DR = 4'h3;
    localparam logic [3:0] EX2_DR = 4'h0;
    localparam logic [3:0] UPD_DR = 4'h5;
    localparam logic [3:0] SEL_IR = 4'h4;
    localparam logic [3:0] CAP_IR = 4'hE;
    localparam logic [3:0] SH_IR  = 4'hA;
    localparam logic [3:0] EX1_IR = 4'h9;
    localparam logic [3:0] PAU_IR = 4'hB;
    localparam logic [3:0] EX2_IR = 4'h8;
    localparam logic [3:0] UPD_IR = 4'hD;

    localparam int WARM_W = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_prev;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   tck_s, tms_s, tdi_s, rise, fall;

    logic [3:0]        state, next_state;
    logic [IR_LEN-1:0] ir_shift, ir_value;
    logic [31:0]       idcode_shift;
    logic              bypass_reg;
    logic [DR_LEN-1:0] user_shift, update_data;
    logic              tdo, capture_strobe, update_valid;
    logic              sel_idcode, sel_user, dr_lsb;

    assign tck_s = tck_sync[SYNC_STAGES-1];
    assign tms_s = tms_sync[SYNC_STAGES-1];
    assign tdi_s = tdi_sync[SYNC_STAGES-1];

    // Edges stay masked until the synchronizers have flushed out their reset zeros.
    assign rise = tck_s & ~tck_prev & (warm_cnt == '0);
    assign fall = ~tck_s & tck_prev & (warm_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
            warm_cnt <= WARM_W'(SYNC_STAGES + 1);
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], bus.tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], bus.tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], bus.tdi};
            tck_prev <= tck_s;
            if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TLR:     next_state = tms_s ? TLR    : RTI;
            RTI:     next_state = tms_s ? SEL_DR : RTI;
            SEL_DR:  next_state = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms_s ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms_s ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms_s ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = tms_s ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = tms_s ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms_s ? SEL_DR : RTI;
            SEL_IR:  next_state = tms_s ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms_s ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms_s ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms_s ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = tms_s ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = tms_s ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms_s ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    assign sel_idcode = (ir_value == IR_LEN'(1));
    assign sel_user   = !sel_idcode && (ir_value == USER_IR);
    assign dr_lsb     = sel_idcode ? idcode_shift[0] : (sel_user ? user_shift[0] : bypass_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= TLR;
            ir_value       <= IR_LEN'(1);
            ir_shift       <= '0;
            idcode_shift   <= '0;
            bypass_reg     <= 1'b0;
            user_shift     <= '0;
            update_data    <= '0;
            tdo            <= 1'b0;
            capture_strobe <= 1'b0;
            update_valid   <= 1'b0;
        end else begin
            capture_strobe <= 1'b0;
            update_valid   <= 1'b0;
            if (rise) begin
                case (state)
                    CAP_IR: ir_shift <= IR_LEN'(1);
                    SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
                    CAP_DR: begin
                        if (sel_idcode) begin
                            idcode_shift <= IDCODE_VAL;
                        end else if (sel_user) begin
                            user_shift     <= bus.dr_capture_data;
                            capture_strobe <= 1'b1;
                        end else begin
                            bypass_reg <= 1'b0;
                        end
                    end
                    SH_DR: begin
                        if (sel_idcode)
                            idcode_shift <= {tdi_s, idcode_shift[31:1]};
                        else if (sel_user)
                            user_shift <= (user_shift >> 1) | (DR_LEN'(tdi_s) << (DR_LEN - 1));
                        else
                            bypass_reg <= tdi_s;
                    end
                    default: ;
                endcase
                state <= next_state;
                if (next_state == TLR) ir_value <= IR_LEN'(1);
            end else if (fall) begin
                tdo <= (state == SH_IR) ? ir_shift[0] : ((state == SH_DR) ? dr_lsb : 1'b0);
                if (state == UPD_IR) ir_value <= ir_shift;
                if (state == UPD_DR && sel_user) begin
                    update_data  <= user_shift;
                    update_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.tdo               = tdo;
    assign bus.tap_state         = state;
    assign bus.ir_value          = ir_value;
    assign bus.dr_capture_strobe = capture_strobe;
    assign bus.dr_update_data    = update_data;
    assign bus.dr_update_valid   = update_valid;
endmodule
